// File: rtl/otter_commit_unit.sv
// rtl/otter_commit_unit.sv - in-order dual-retire commit buffer driving both register-file write ports
module otter_commit_unit #(
  parameter  int DEPTH = 8,
  parameter  int XLEN  = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_req,
  input  logic             alloc_req_2,
  input  logic [4:0]       alloc_rd,
  input  logic [4:0]       alloc_rd_2,
  input  logic             alloc_we,
  input  logic             alloc_we_2,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  output logic [TAG_W-1:0] alloc_tag_2,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic [XLEN-1:0]  res_data,
  input  logic             res_valid_2,
  input  logic [TAG_W-1:0] res_tag_2,
  input  logic [XLEN-1:0]  res_data_2,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [XLEN-1:0]  WriteData,
  output logic             RegWrite_2,
  output logic [4:0]       WriteReg_2,
  output logic [XLEN-1:0]  WriteData_2,
  output logic [TAG_W:0]   count
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] we_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic [TAG_W-1:0] head_1;
  logic [TAG_W-1:0] tail_1;
  logic             do_alloc;
  logic             do_alloc_2;
  logic             commit_0;
  logic             commit_1;
  logic             wr_0;
  logic             wr_1;
  logic [TAG_W:0]   n_alloc;
  logic [TAG_W:0]   n_commit;

  // Pointer wrap is free because DEPTH is a power of two.
  assign head_1      = head_q + TAG_W'(1);
  assign tail_1      = tail_q + TAG_W'(1);
  assign alloc_tag   = tail_q;
  assign alloc_tag_2 = tail_1;
  assign count       = count_q;
  // Two free slots are always required so a pair can be accepted without peeking at the request.
  assign alloc_ready = (count_q <= (TAG_W+1)'(DEPTH - 2));

  // Decide this cycle's allocations, retirements and register-file writes.
  always_comb begin
    do_alloc   = alloc_req & alloc_ready;
    do_alloc_2 = do_alloc & alloc_req_2;
    commit_0   = valid_q[head_q] & done_q[head_q];
    commit_1   = commit_0 & valid_q[head_1] & done_q[head_1];
    wr_1       = commit_1 & we_q[head_1] & (rd_q[head_1] != 5'd0);
    // Younger write to the same register supersedes the older one.
    wr_0       = commit_0 & we_q[head_q] & (rd_q[head_q] != 5'd0)
                 & ~(wr_1 & (rd_q[head_1] == rd_q[head_q]));
    n_alloc    = (TAG_W+1)'(do_alloc) + (TAG_W+1)'(do_alloc_2);
    n_commit   = (TAG_W+1)'(commit_0) + (TAG_W+1)'(commit_1);
  end

  // Entry status flags and queue pointers; results land before commits clear, allocs go to free slots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (res_valid && valid_q[res_tag])
        done_q[res_tag] <= 1'b1;
      if (res_valid_2 && valid_q[res_tag_2])
        done_q[res_tag_2] <= 1'b1;
      if (commit_0) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (commit_1) begin
        valid_q[head_1] <= 1'b0;
        done_q[head_1]  <= 1'b0;
      end
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
      if (do_alloc_2) begin
        valid_q[tail_1] <= 1'b1;
        done_q[tail_1]  <= 1'b0;
      end
      head_q  <= head_q + n_commit[TAG_W-1:0];
      tail_q  <= tail_q + n_alloc[TAG_W-1:0];
      count_q <= count_q + n_alloc - n_commit;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set, so it needs no reset.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (res_valid && valid_q[res_tag])
        data_q[res_tag] <= res_data;
      if (res_valid_2 && valid_q[res_tag_2])
        data_q[res_tag_2] <= res_data_2;
      if (do_alloc) begin
        we_q[tail_q] <= alloc_we;
        rd_q[tail_q] <= alloc_rd;
      end
      if (do_alloc_2) begin
        we_q[tail_1] <= alloc_we_2;
        rd_q[tail_1] <= alloc_rd_2;
      end
    end
  end

  // Registered write commands; address/data hold when nothing retires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWrite    <= 1'b0;
      RegWrite_2  <= 1'b0;
      WriteReg    <= '0;
      WriteReg_2  <= '0;
      WriteData   <= '0;
      WriteData_2 <= '0;
    end else if (flush) begin
      RegWrite   <= 1'b0;
      RegWrite_2 <= 1'b0;
    end else begin
      RegWrite   <= wr_0;
      RegWrite_2 <= wr_1;
      if (commit_0) begin
        WriteReg  <= rd_q[head_q];
        WriteData <= data_q[head_q];
      end
      if (commit_1) begin
        WriteReg_2  <= rd_q[head_1];
        WriteData_2 <= data_q[head_1];
      end
    end
  end

endmodule

// File: tb/tb_otter_commit_unit.sv
// tb/tb_otter_commit_unit.sv - scoreboard bench for otter_commit_unit
module tb_otter_commit_unit;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int TAG_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             alloc_req = 1'b0, alloc_req_2 = 1'b0;
  logic [4:0]       alloc_rd = '0, alloc_rd_2 = '0;
  logic             alloc_we = 1'b0, alloc_we_2 = 1'b0;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag, alloc_tag_2;
  logic             res_valid = 1'b0, res_valid_2 = 1'b0;
  logic [TAG_W-1:0] res_tag = '0, res_tag_2 = '0;
  logic [XLEN-1:0]  res_data = '0, res_data_2 = '0;
  logic             RegWrite, RegWrite_2;
  logic [4:0]       WriteReg, WriteReg_2;
  logic [XLEN-1:0]  WriteData, WriteData_2;
  logic [TAG_W:0]   count;

  otter_commit_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_req(alloc_req), .alloc_req_2(alloc_req_2),
    .alloc_rd(alloc_rd), .alloc_rd_2(alloc_rd_2),
    .alloc_we(alloc_we), .alloc_we_2(alloc_we_2),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .alloc_tag_2(alloc_tag_2),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_valid_2(res_valid_2), .res_tag_2(res_tag_2), .res_data_2(res_data_2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .RegWrite_2(RegWrite_2), .WriteReg_2(WriteReg_2), .WriteData_2(WriteData_2),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        port;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.port = p;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic p, input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_write: port %0d rd %0d data 0x%0h, expected no write", p, r, d);
    end else begin
      e = exp_q.pop_front();
      check("wr_port", 32'(p), 32'(e.port));
      check("wr_rd",   32'(r), 32'(e.rd));
      check("wr_data", d, e.data);
    end
  endtask

  // Monitor: every write strobe seen on a negedge must match the next expected commit.
  always @(negedge clock) begin
    if (!reset) begin
      if (RegWrite === 1'b1)   pop_check(1'b0, WriteReg, WriteData);
      if (RegWrite_2 === 1'b1) pop_check(1'b1, WriteReg_2, WriteData_2);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    alloc_req   = 1'b0;
    alloc_req_2 = 1'b0;
    res_valid   = 1'b0;
    res_valid_2 = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_alloc(input logic two, input logic [4:0] r0, input logic w0,
                           input logic [4:0] r1, input logic w1);
    alloc_req   = 1'b1;
    alloc_req_2 = two;
    alloc_rd    = r0;
    alloc_we    = w0;
    alloc_rd_2  = r1;
    alloc_we_2  = w1;
  endtask

  task automatic set_res0(input logic [TAG_W-1:0] t, input logic [31:0] d);
    res_valid = 1'b1;
    res_tag   = t;
    res_data  = d;
  endtask

  task automatic set_res1(input logic [TAG_W-1:0] t, input logic [31:0] d);
    res_valid_2 = 1'b1;
    res_tag_2   = t;
    res_data_2  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_regwrite", 32'(RegWrite), 0);
    check("rst_regwrite_2", 32'(RegWrite_2), 0);
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    check("rst_writereg", 32'(WriteReg), 0);
    @(negedge clock);
    reset = 1'b0;

    // Pair x5/x6, results out of order
    set_alloc(1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
    check("pair_tag", 32'(alloc_tag), 0);
    check("pair_tag_2", 32'(alloc_tag_2), 1);
    tick();
    check("pair_count", 32'(count), 2);
    push_exp(1'b0, 5'd5, 32'h55);
    push_exp(1'b1, 5'd6, 32'h66);
    set_res0(3'd1, 32'h66);
    tick();
    set_res0(3'd0, 32'h55);
    tick();
    check("latency_no_write", 32'(RegWrite), 0);
    tick();
    check("pair_regwrite", 32'(RegWrite), 1);
    check("pair_regwrite_2", 32'(RegWrite_2), 1);
    check("pair_count_after", 32'(count), 0);

    // Fill to 7, tail wraps onto tag 0
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 5'(8 + 2*i), 1'b1, 5'(9 + 2*i), 1'b1);
      check("fill_ready", 32'(alloc_ready), 1);
      tick();
    end
    check("fill_count6", 32'(count), 6);
    check("wrap_tag0", 32'(alloc_tag), 0);
    set_alloc(1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    tick();
    check("fill_count7", 32'(count), 7);
    check("full_not_ready", 32'(alloc_ready), 0);
    check("tail_after_wrap", 32'(alloc_tag), 1);
    set_alloc(1'b1, 5'd20, 1'b1, 5'd21, 1'b1);
    tick();
    check("blocked_alloc", 32'(count), 7);

    set_res0(3'd3, 32'h300); set_res1(3'd2, 32'h200);
    push_exp(1'b0, 5'd8, 32'h200); push_exp(1'b1, 5'd9, 32'h300);
    tick();
    check("drain_count7", 32'(count), 7);
    set_res0(3'd5, 32'h500); set_res1(3'd4, 32'h400);
    push_exp(1'b0, 5'd10, 32'h400); push_exp(1'b1, 5'd11, 32'h500);
    tick();
    check("drain_count5", 32'(count), 5);
    check("drain_ready", 32'(alloc_ready), 1);
    set_res0(3'd7, 32'h700); set_res1(3'd6, 32'h600);
    push_exp(1'b0, 5'd12, 32'h600); push_exp(1'b1, 5'd13, 32'h700);
    tick();
    set_res0(3'd0, 32'hDEAD);
    tick();
    tick();
    check("x0_no_write", 32'(RegWrite), 0);
    check("x0_no_write_2", 32'(RegWrite_2), 0);
    check("x0_retired", 32'(count), 0);
    check("reissue_tag1", 32'(alloc_tag), 1);

    // Result to a freed tag is dropped
    set_res0(3'd3, 32'h333);
    tick();
    check("freed_count", 32'(count), 0);

    // Same rd in both slots: younger wins
    set_alloc(1'b1, 5'd7, 1'b1, 5'd7, 1'b1);
    tick();
    set_res0(3'd1, 32'h11); set_res1(3'd2, 32'h22);
    push_exp(1'b1, 5'd7, 32'h22);
    tick();
    tick();
    check("dup_regwrite", 32'(RegWrite), 0);
    check("dup_regwrite_2", 32'(RegWrite_2), 1);
    check("dup_writereg_2", 32'(WriteReg_2), 7);
    check("dup_writedata_2", WriteData_2, 32'h22);

    // Tag 3 reallocated: the earlier stray result must not have marked it done
    set_alloc(1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    check("realloc_tag3", 32'(alloc_tag), 3);
    tick();
    tick();
    check("stray_not_done", 32'(count), 1);
    set_res0(3'd3, 32'hAA); set_res1(3'd3, 32'hBB);
    push_exp(1'b0, 5'd9, 32'hBB);
    tick();
    tick();
    check("same_tag_regwrite", 32'(RegWrite), 1);
    check("same_tag_lane1_wins", WriteData, 32'hBB);

    // Flush with result and alloc in the same cycle
    set_alloc(1'b1, 5'd14, 1'b1, 5'd15, 1'b1);
    tick();
    check("preflush_count", 32'(count), 2);
    flush = 1'b1;
    set_res0(3'd4, 32'h44);
    set_alloc(1'b1, 5'd16, 1'b1, 5'd17, 1'b1);
    tick();
    check("flush_count", 32'(count), 0);
    check("flush_regwrite", 32'(RegWrite), 0);
    check("flush_tail", 32'(alloc_tag), 0);
    set_res0(3'd4, 32'h45);
    tick();
    tick();
    check("old_tag_dropped", 32'(count), 0);
    set_alloc(1'b1, 5'd16, 1'b1, 5'd17, 1'b1);
    tick();
    set_res0(3'd0, 32'h160); set_res1(3'd1, 32'h170);
    push_exp(1'b0, 5'd16, 32'h160); push_exp(1'b1, 5'd17, 32'h170);
    tick();
    tick();
    check("postflush_regwrite", 32'(RegWrite), 1);
    check("postflush_regwrite_2", 32'(RegWrite_2), 1);

    // Reset mid-traffic with 5 entries held and a write strobe up
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 5'(20 + 2*i), 1'b1, 5'(21 + 2*i), 1'b1);
      tick();
    end
    set_alloc(1'b0, 5'd26, 1'b1, 5'd0, 1'b0);
    tick();
    set_res0(3'd2, 32'h20); set_res1(3'd3, 32'h21);
    push_exp(1'b0, 5'd20, 32'h20); push_exp(1'b1, 5'd21, 32'h21);
    tick();
    tick();
    check("mid_count5", 32'(count), 5);
    check("mid_regwrite", 32'(RegWrite), 1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_regwrite", 32'(RegWrite), 0);
    check("async_rst_regwrite_2", 32'(RegWrite_2), 0);
    check("async_rst_tag", 32'(alloc_tag), 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
